alu_muldiv: RTL and testbench

Multi-cycle integer multiply/divide unit that sits beside the single-cycle `alu` in the execute stage and implements the RISC-V M-extension operations. Operand width is parametrised (`XLEN`). Operations are issued with a valid/ready handshake, execute iteratively one bit per cycle, and the result is held until the consumer accepts it. A flush input aborts any in-flight operation on a pipeline redirect.

---
 rtl/alu_muldiv.sv | 168 ++++++++++++++++
 tb/tb_alu_muldiv.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply, restoring divide.
// Optional macro ALU_MULDIV_FAST_MUL_EN replaces the multiply path with a single-cycle multiplier.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_y
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0]   ONE   = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE2  = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   ZERO  = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ALL1  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   MINV  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]     CNT_LOAD = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;
    logic              neg_q;
    logic              rneg_q;
    logic [XLEN-1:0]   y_q;

    logic              a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s;
    logic              special_s;
    logic [XLEN-1:0]   special_y_s;
    logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [2*XLEN-1:0] step_s, mul_full_s;
    logic [XLEN-1:0]   calc_y_s;

    // Operand signedness, magnitudes and divide special cases for the incoming request.
    always_comb begin
        a_signed_s  = (i_op == 3'b001) || (i_op == 3'b010) || (i_op == 3'b100) || (i_op == 3'b110);
        b_signed_s  = (i_op == 3'b001) || (i_op == 3'b100) || (i_op == 3'b110);
        a_neg_s     = a_signed_s & i_a[XLEN-1];
        b_neg_s     = b_signed_s & i_b[XLEN-1];
        a_mag_s     = a_neg_s ? (~i_a + ONE) : i_a;
        b_mag_s     = b_neg_s ? (~i_b + ONE) : i_b;
        special_s   = 1'b0;
        special_y_s = ZERO;
        if (i_op[2] && (i_b == ZERO)) begin
            special_s   = 1'b1;
            special_y_s = i_op[1] ? i_a : ALL1;
        end else if ((i_op == 3'b100 || i_op == 3'b110) && (i_a == MINV) && (i_b == ALL1)) begin
            special_s   = 1'b1;
            special_y_s = i_op[1] ? ZERO : i_a;
        end else begin
            special_s   = 1'b0;
        end
    end

    // One iteration step: hi half is partial product / remainder, lo half multiplier / dividend.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        div_shift_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (div_diff_s[XLEN]) begin
                step_s = {div_shift_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end else begin
                step_s = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else begin
            step_s = {mul_sum_s, acc_q[XLEN-1:1]};
        end
        mul_full_s = neg_q ? (~step_s + ONE2) : step_s;
    end

    // Sign-corrected result selection after the final step.
    always_comb begin
        case (op_q)
            3'b000:                 calc_y_s = mul_full_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: calc_y_s = mul_full_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         calc_y_s = neg_q ? (~step_s[XLEN-1:0] + ONE) : step_s[XLEN-1:0];
            3'b110, 3'b111:         calc_y_s = rneg_q ? (~step_s[2*XLEN-1:XLEN] + ONE) : step_s[2*XLEN-1:XLEN];
            default:                calc_y_s = ZERO;
        endcase
    end

`ifdef ALU_MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fa_s, fb_s;
    logic signed [2*XLEN+1:0] fprod_s;
    logic [XLEN-1:0]          fast_y_s;

    // Single-cycle signed multiply; the extra operand bit carries per-op signedness.
    always_comb begin
        fa_s     = {a_signed_s & i_a[XLEN-1], i_a};
        fb_s     = {b_signed_s & i_b[XLEN-1], i_b};
        fprod_s  = fa_s * fb_s;
        fast_y_s = (i_op[1:0] == 2'b00) ? fprod_s[XLEN-1:0] : fprod_s[2*XLEN-1:XLEN];
    end
`endif

    // Control FSM with datapath registers; flush overrides accept and the result handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            op_q    <= 3'b000;
            opnd_q  <= ZERO;
            acc_q   <= {(2*XLEN){1'b0}};
            cnt_q   <= {CW{1'b0}};
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            y_q     <= ZERO;
        end else if (i_flush) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        op_q   <= i_op;
                        neg_q  <= a_neg_s ^ b_neg_s;
                        rneg_q <= a_neg_s;
                        if (special_s) begin
                            y_q     <= special_y_s;
                            state_q <= DONE;
`ifdef ALU_MULDIV_FAST_MUL_EN
                        end else if (!i_op[2]) begin
                            y_q     <= fast_y_s;
                            state_q <= DONE;
`endif
                        end else begin
                            opnd_q  <= i_op[2] ? b_mag_s : a_mag_s;
                            acc_q   <= {ZERO, i_op[2] ? a_mag_s : b_mag_s};
                            cnt_q   <= CNT_LOAD;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= step_s;
                    if (cnt_q == {CW{1'b0}}) begin
                        y_q     <= calc_y_s;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign o_y     = y_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (XLEN=32) using immediate assertions.
module tb_alu_muldiv;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_op = 3'b000;
    logic [31:0] i_a = 32'd0;
    logic [31:0] i_b = 32'd0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_y;

    int checks = 0;
    int errors = 0;
    int mul_lat;

    alu_muldiv #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_y(o_y)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle, wait for o_valid (bounded), check latency and result.
    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat_exp, input logic [31:0] y_exp);
        int lat;
        @(negedge i_clk);
        i_valid = 1'b1; i_op = op; i_a = a; i_b = b;
        lat = 0;
        do begin
            @(posedge i_clk); #1;
            if (lat == 0) i_valid = 1'b0;
            lat++;
        end while (!o_valid && lat < 100);
        check({tag, "_lat"}, lat, lat_exp);
        check(tag, o_y, y_exp);
    endtask

    task automatic ack();
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        check("ack_ready", {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        bit saw_valid;
        logic [31:0] held;
`ifdef ALU_MULDIV_FAST_MUL_EN
        mul_lat = 1;
`else
        mul_lat = 33;
`endif
        #12;
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_y", o_y, 32'd0);
        i_rst_n = 1'b1;

        issue("mulh_m1x2",   3'b001, 32'hFFFFFFFF, 32'd2, mul_lat, 32'hFFFFFFFF); ack();
        issue("mulhu_m1x2",  3'b011, 32'hFFFFFFFF, 32'd2, mul_lat, 32'h00000001); ack();
        issue("mulhsu_m1x2", 3'b010, 32'hFFFFFFFF, 32'd2, mul_lat, 32'hFFFFFFFF); ack();
        issue("mul_m3x5",    3'b000, 32'hFFFFFFFD, 32'd5, mul_lat, 32'hFFFFFFF1); ack();
        issue("mulh_big",    3'b001, 32'h80000000, 32'h80000000, mul_lat, 32'h40000000); ack();
        issue("div_m7_2",    3'b100, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD); ack();
        issue("rem_m7_2",    3'b110, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF); ack();
        issue("div_7_m2",    3'b100, 32'd7, 32'hFFFFFFFE, 33, 32'hFFFFFFFD); ack();
        issue("rem_7_m2",    3'b110, 32'd7, 32'hFFFFFFFE, 33, 32'h00000001); ack();
        issue("divu_100_7",  3'b101, 32'd100, 32'd7, 33, 32'd14); ack();
        issue("remu_100_7",  3'b111, 32'd100, 32'd7, 33, 32'd2); ack();
        issue("divu_by0",    3'b101, 32'h1234, 32'd0, 1, 32'hFFFFFFFF); ack();
        issue("rem_by0",     3'b110, 32'h1234, 32'd0, 1, 32'h00001234); ack();
        issue("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000); ack();
        issue("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000); ack();

        // Backpressure: result held, unit not ready, new request ignored.
        issue("bp_divu", 3'b101, 32'd100, 32'd7, 33, 32'd14);
        held = o_y;
        @(negedge i_clk);
        i_valid = 1'b1; i_op = 3'b101; i_a = 32'd50; i_b = 32'd0;
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            check("bp_y", o_y, 32'd14);
            check("bp_ready", {31'd0, o_ready}, 32'd0);
            check("bp_valid", {31'd0, o_valid}, 32'd1);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        ack();
        check("bp_valid_after", {31'd0, o_valid}, 32'd0);
        check("bp_y_after", o_y, held);

        // Flush during CALC cycle 10.
        @(negedge i_clk);
        i_valid = 1'b1; i_op = 3'b101; i_a = 32'd1000; i_b = 32'd3;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        check("fl_busy", {31'd0, o_ready}, 32'd0);
        repeat (9) @(posedge i_clk);
        @(negedge i_clk);
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        check("fl_ready", {31'd0, o_ready}, 32'd1);
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge i_clk); #1;
            if (o_valid) saw_valid = 1'b1;
        end
        check("fl_no_valid", {31'd0, saw_valid}, 32'd0);

        // Request and flush in the same cycle must not be accepted.
        @(negedge i_clk);
        i_valid = 1'b1; i_flush = 1'b1; i_op = 3'b101; i_a = 32'd5; i_b = 32'd0;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        check("fl_acc_ready", {31'd0, o_ready}, 32'd1);
        check("fl_acc_valid", {31'd0, o_valid}, 32'd0);

        // Asynchronous reset mid-CALC.
        @(negedge i_clk);
        i_valid = 1'b1; i_op = 3'b101; i_a = 32'd999; i_b = 32'd4;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, o_valid}, 32'd0);
        check("ar_ready", {31'd0, o_ready}, 32'd1);
        check("ar_y", o_y, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        issue("mul_3x5", 3'b000, 32'd3, 32'd5, mul_lat, 32'd15); ack();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
